// File: rtl/wlm_pipe.sv
// wlm_pipe: pipelined word-level Montgomery reduction for moduli q = qH*2^WS + 1.
// Each iteration strips WS low bits of the running value using q == 1 mod 2^WS, so
// only a WS x LOGQH product by qH is needed per iteration. The result is
// T = C * 2^(-NITER*WS) mod q, or a congruent value below 2q when CORRECT = 0.
// A single conditional subtraction is applied, so full reduction assumes the
// iterations leave the value below 2q (true for NITER >= 2 and small qH).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_ready is the global advance
//   qH, C                 per-sample modulus high part and value to reduce
//   out_valid/out_ready   output handshake
//   T                     reduced result, forced to 0 while out_valid = 0
//   out_err               (WLM_PIPE_RANGE_CHECK_EN only) C >= q^2 for this sample
//
// Optional feature macro: WLM_PIPE_RANGE_CHECK_EN adds the out_err port and flag.
module wlm_pipe #(
   parameter int unsigned LOGQ    = 14,
   parameter int unsigned LOGQH   = 2,
   parameter int unsigned NITER   = 2,
   parameter int unsigned CORRECT = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LOGQH-1:0]       qH,
   input  logic [2*LOGQ-1:0]      C,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [((CORRECT != 0) ? LOGQ : LOGQ+1)-1:0] T
`ifdef WLM_PIPE_RANGE_CHECK_EN
  ,output logic                   out_err
`endif
);

   localparam int unsigned WS  = LOGQ - LOGQH;
   localparam int unsigned DW  = 2*LOGQ + 1;
   localparam int unsigned MW  = WS + LOGQH;
   localparam int unsigned LAT = 2*NITER + ((CORRECT != 0) ? 1 : 0) + 1;
   localparam int unsigned OS  = LAT - 1;
   localparam int unsigned TW  = (CORRECT != 0) ? LOGQ : LOGQ + 1;

   // Stage registers: iteration i uses stages 2i (split) and 2i+1 (accumulate),
   // then the optional correction stage, then the output stage OS.
   logic             v_r  [LAT];
   logic [LOGQH-1:0] qh_r [LAT];
   logic [DW-1:0]    d_r  [LAT];
   logic [MW-1:0]    mq_r [NITER];

   logic             v_n  [LAT];
   logic [LOGQH-1:0] qh_n [LAT];
   logic [DW-1:0]    d_n  [LAT];
   logic [MW-1:0]    mq_n [NITER];
   logic [DW-1:0]    src  [NITER];

   logic adv;

   // Whole pipeline advances together; a full output stage stalls everything.
   assign adv       = ~v_r[OS] | out_ready;
   assign in_ready  = adv;
   assign out_valid = v_r[OS];
   assign T         = TW'(d_r[OS]);

   // Next-state for all stages.
   always_comb begin
      logic [WS-1:0] lo;
      logic [WS-1:0] m;
      logic [DW-1:0] qf;
      lo = '0;
      m  = '0;
      qf = '0;
      for (int unsigned i = 0; i < LAT; i++) begin
         v_n[i]  = 1'b0;
         qh_n[i] = '0;
         d_n[i]  = '0;
      end
      for (int unsigned i = 0; i < NITER; i++) begin
         mq_n[i] = '0;
         src[i]  = '0;
      end

      v_n[0]  = in_valid;
      qh_n[0] = qH;
      for (int unsigned i = 1; i < LAT; i++) begin
         v_n[i]  = v_r[i-1];
         qh_n[i] = qh_r[i-1];
      end

      src[0] = DW'(C);
      for (int unsigned it = 1; it < NITER; it++) begin
         src[it] = d_r[2*it-1];
      end

      // (x + m*q) / 2^WS with m = -x mod 2^WS: low word plus m is 0 or 2^WS,
      // so the carry is simply "low word nonzero".
      for (int unsigned it = 0; it < NITER; it++) begin
         lo              = src[it][WS-1:0];
         m               = WS'(0) - lo;
         d_n[2*it]       = (src[it] >> WS) + DW'(|lo);
         mq_n[it]        = MW'(m) * MW'(qh_n[2*it]);
         d_n[2*it+1]     = d_r[2*it] + DW'(mq_r[it]);
      end

      if (CORRECT != 0) begin
         qf             = (DW'(qh_r[2*NITER-1]) << WS) | DW'(1);
         d_n[2*NITER]   = (d_r[2*NITER-1] >= qf) ? (d_r[2*NITER-1] - qf)
                                                 : d_r[2*NITER-1];
      end

      // Output stage holds zero whenever it carries a bubble.
      d_n[OS] = v_r[OS-1] ? d_r[OS-1] : '0;
   end

   // Stage registers update only on global advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < LAT; i++) begin
            v_r[i]  <= 1'b0;
            qh_r[i] <= '0;
            d_r[i]  <= '0;
         end
         for (int unsigned i = 0; i < NITER; i++) begin
            mq_r[i] <= '0;
         end
      end else if (adv) begin
         v_r  <= v_n;
         qh_r <= qh_n;
         d_r  <= d_n;
         mq_r <= mq_n;
      end
   end

`ifdef WLM_PIPE_RANGE_CHECK_EN
   localparam int unsigned QW = 2*LOGQ;

   logic          e_r [LAT];
   logic          e_n [LAT];
   logic [QW-1:0] qsq;

   // q^2 = qH^2*2^(2WS) + qH*2^(WS+1) + 1, built from the narrow qH only.
   assign qsq = ((QW'(qH) * QW'(qH)) << (2*WS)) + (QW'(qH) << (WS+1)) + QW'(1);

   // Range flag travels alongside its sample and is cleared for bubbles.
   always_comb begin
      for (int unsigned i = 0; i < LAT; i++) begin
         e_n[i] = 1'b0;
      end
      e_n[0] = (C >= qsq);
      for (int unsigned i = 1; i < LAT; i++) begin
         e_n[i] = e_r[i-1];
      end
      e_n[OS] = v_r[OS-1] & e_r[OS-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < LAT; i++) begin
            e_r[i] <= 1'b0;
         end
      end else if (adv) begin
         e_r <= e_n;
      end
   end

   assign out_err = e_r[OS];
`endif

endmodule

// File: tb/tb_wlm_pipe.sv
// tb_wlm_pipe: directed self-checking bench for wlm_pipe at default parameters
// (LOGQ=14, LOGQH=2, NITER=2, CORRECT=1, latency 6). With qH=3, q=12289 and
// 2^-24 == 9 mod q; with qH=1, q=4097 and 2^24 == 1 mod q.
module tb_wlm_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  qH = 2'd0;
   logic [27:0] C = 28'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [13:0] T;
`ifdef WLM_PIPE_RANGE_CHECK_EN
   logic        out_err;
`endif

   wlm_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .qH        (qH),
      .C         (C),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .T         (T)
`ifdef WLM_PIPE_RANGE_CHECK_EN
     ,.out_err   (out_err)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   logic        zero_bad = 1'b0;
   logic [13:0] t_q [$];
   logic        e_q [$];
   int          oc_q [$];
   int          acc_q [$];

   // Observe handshakes mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) acc_q.push_back(cyc);
         if (out_valid && out_ready) begin
            t_q.push_back(T);
            oc_q.push_back(cyc);
`ifdef WLM_PIPE_RANGE_CHECK_EN
            e_q.push_back(out_err);
`else
            e_q.push_back(1'b0);
`endif
         end
         if (!out_valid && T != 14'd0) zero_bad = 1'b1;
`ifdef WLM_PIPE_RANGE_CHECK_EN
         if (!out_valid && out_err) zero_bad = 1'b1;
`endif
      end
   end

   task automatic clr();
      t_q.delete(); e_q.delete(); oc_q.delete(); acc_q.delete();
   endtask

   // Called at posedge+1; returns at posedge+1 after the sample is accepted.
   task automatic send(input logic [1:0] h, input logic [27:0] c);
      int k = 0;
      in_valid = 1'b1; qH = h; C = c;
      @(negedge clk);
      while (!in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout got in_ready=%0b want=1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input int n);
      int k = 0;
      while (t_q.size() < n && k < 200) begin
         @(posedge clk);
         k++;
      end
      repeat (8) @(posedge clk);
      #1;
      checks++;
      if (t_q.size() !== n) begin
         errors++;
         $display("FAIL drain_count got=%0d want=%0d", t_q.size(), n);
      end
   endtask

   task automatic test_reset();
      int acc;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
      checks++; if (T !== 14'd0) begin errors++; $display("FAIL rst_T got=%0d want=0", T); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0b want=1", in_ready); end
      clr();
      // Release with a sample already presented: it must go in on the first edge.
      @(negedge clk); #1;
      rst_n = 1'b1; in_valid = 1'b1; qH = 2'd3; C = 28'd83886080;
      acc = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain(1);
      if (t_q.size() == 1) begin
         checks++; if (t_q[0] !== 14'd5) begin errors++; $display("FAIL first_T got=%0d want=5", t_q[0]); end
         checks++; if (oc_q[0] - acc !== 6) begin errors++; $display("FAIL first_latency got=%0d want=6", oc_q[0] - acc); end
      end
   endtask

   task automatic test_latency();
      clr();
      send(2'd3, 28'd83886080);
      drain(1);
      if (t_q.size() == 1 && acc_q.size() == 1) begin
         checks++; if (t_q[0] !== 14'd5) begin errors++; $display("FAIL lat_T got=%0d want=5", t_q[0]); end
         checks++; if (oc_q[0] - acc_q[0] !== 6) begin errors++; $display("FAIL latency got=%0d want=6", oc_q[0] - acc_q[0]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [13:0] exp [3];
      exp[0] = 14'd3; exp[1] = 14'd9; exp[2] = 14'd0;
      clr();
      send(2'd3, 28'd50331648);
      send(2'd3, 28'd150994944);
      send(2'd3, 28'd0);
      drain(3);
      if (t_q.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            checks++; if (t_q[i] !== exp[i]) begin errors++; $display("FAIL b2b_T[%0d] got=%0d want=%0d", i, t_q[i], exp[i]); end
         end
         for (int i = 1; i < 3; i++) begin
            checks++; if (oc_q[i] - oc_q[i-1] !== 1) begin errors++; $display("FAIL b2b_gap[%0d] got=%0d want=1", i, oc_q[i] - oc_q[i-1]); end
         end
      end
   endtask

   task automatic test_values();
      logic [1:0]  vh [8];
      logic [27:0] vc [8];
      logic [13:0] vt [8];
      // qH=3: T = 9*C mod 12289. qH=1: T = C mod 4097.
      vh[0] = 2'd3; vc[0] = 28'd1;          vt[0] = 14'd9;
      vh[1] = 2'd3; vc[1] = 28'd1366;       vt[1] = 14'd5;
      vh[2] = 2'd3; vc[2] = 28'd1365;       vt[2] = 14'd12285;
      vh[3] = 2'd3; vc[3] = 28'd151019520;  vt[3] = 14'd12280;
      vh[4] = 2'd3; vc[4] = 28'd12289;      vt[4] = 14'd0;
      vh[5] = 2'd3; vc[5] = 28'd50335744;   vt[5] = 14'd0;
      vh[6] = 2'd1; vc[6] = 28'd4098;       vt[6] = 14'd1;
      vh[7] = 2'd1; vc[7] = 28'd16785408;   vt[7] = 14'd4096;
      clr();
      for (int i = 0; i < 8; i++) send(vh[i], vc[i]);
      drain(8);
      if (t_q.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            checks++; if (t_q[i] !== vt[i]) begin errors++; $display("FAIL val_T[%0d] got=%0d want=%0d", i, t_q[i], vt[i]); end
         end
      end
   endtask

   task automatic test_mixed_qh();
      clr();
      for (int i = 0; i < 4; i++) send((i % 2 == 0) ? 2'd3 : 2'd1, 28'd33554432);
      drain(4);
      if (t_q.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (t_q[i] !== 14'd2) begin errors++; $display("FAIL mix_T[%0d] got=%0d want=2", i, t_q[i]); end
         end
      end
   endtask

   task automatic test_bubble();
      clr();
      send(2'd3, 28'd16777216);
      @(posedge clk); #1;
      send(2'd3, 28'd33554432);
      drain(2);
      if (t_q.size() == 2) begin
         checks++; if (t_q[0] !== 14'd1) begin errors++; $display("FAIL bub_T0 got=%0d want=1", t_q[0]); end
         checks++; if (t_q[1] !== 14'd2) begin errors++; $display("FAIL bub_T1 got=%0d want=2", t_q[1]); end
         checks++; if (oc_q[1] - oc_q[0] !== 2) begin errors++; $display("FAIL bub_gap got=%0d want=2", oc_q[1] - oc_q[0]); end
      end
      checks++; if (zero_bad !== 1'b0) begin errors++; $display("FAIL idle_zero got=%0b want=0", zero_bad); end
   endtask

   task automatic test_stall();
      clr();
      fork
         begin
            for (int k = 0; k < 10; k++) send(2'd3, 28'(k) << 24);
         end
         begin
            repeat (8) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (4) begin
               @(negedge clk);
               checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%0b want=0", in_ready); end
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain(10);
      if (t_q.size() == 10) begin
         for (int k = 0; k < 10; k++) begin
            checks++; if (t_q[k] !== 14'(k)) begin errors++; $display("FAIL stall_T[%0d] got=%0d want=%0d", k, t_q[k], k); end
         end
      end
   endtask

   task automatic test_range();
`ifdef WLM_PIPE_RANGE_CHECK_EN
      clr();
      send(2'd3, 28'd151019521);
      send(2'd3, 28'd151019520);
      drain(2);
      if (e_q.size() == 2) begin
         checks++; if (e_q[0] !== 1'b1) begin errors++; $display("FAIL err_qsq got=%0b want=1", e_q[0]); end
         checks++; if (e_q[1] !== 1'b0) begin errors++; $display("FAIL err_below got=%0b want=0", e_q[1]); end
      end
`endif
   endtask

   task automatic test_reset_midflight();
      int k = 0;
      int n0;
      clr();
      send(2'd3, 28'd16777216);
      send(2'd3, 28'd33554432);
      send(2'd3, 28'd50331648);
      @(negedge clk);
      while (!out_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!out_valid) begin
         checks++; errors++;
         $display("FAIL mid_wait got out_valid=%0b want=1", out_valid);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%0b want=0", out_valid); end
      checks++; if (T !== 14'd0) begin errors++; $display("FAIL mid_T got=%0d want=0", T); end
      n0 = t_q.size();
      repeat (2) @(posedge clk);
      @(negedge clk); #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      checks++; if (t_q.size() !== n0) begin errors++; $display("FAIL mid_ghost got=%0d want=%0d", t_q.size(), n0); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_back_to_back();
      test_values();
      test_mixed_qh();
      test_bubble();
      test_stall();
      test_range();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
